// File: rtl/sprite_frame_store.sv
// sprite_frame_store
//   Multi-frame sprite image store between the VGA address generator and the
//   pixel colour mux. It holds FRAMES images of 2^ADDR_W pixels of PIX_W bits
//   each. Images can be rewritten at runtime. The frame served to reads is
//   chosen manually or auto-animated, and it only changes on frame_tick
//   (start of vertical blank), so a displayed image never tears.
//
//   Ports
//     clk, reset           single clock; synchronous active-high reset
//     rd_en, rd_addr       pixel read within the current frame
//     pix_val, pix_valid   read data and its valid flag
//     wr_en, wr_frame,
//     wr_addr, wr_data     runtime image write; out-of-range frames are dropped
//     frame_tick           one-cycle pulse at start of vertical blank
//     anim_en, anim_hold   auto-advance enable; ticks per frame minus 1
//     frame_sel            manual frame select
//     cur_frame            frame currently served to reads
//
//   Optional feature macro: FRAME_STORE_OUTREG_EN
//     Adds a second output register, so read latency becomes 2.

module sprite_frame_store #(
  parameter int    FRAMES    = 8,
  parameter int    ADDR_W    = 14,
  parameter int    PIX_W     = 1,
  parameter int    HOLD_W    = 4,
  parameter string INIT_FILE = "",
  localparam int   FSEL_W    = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  pix_val,
  output logic              pix_valid,
  input  logic              wr_en,
  input  logic [FSEL_W-1:0] wr_frame,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              frame_tick,
  input  logic              anim_en,
  input  logic [HOLD_W-1:0] anim_hold,
  input  logic [FSEL_W-1:0] frame_sel,
  output logic [FSEL_W-1:0] cur_frame
);

  // With a single frame the frame field carries no information, so the
  // physical index is just the pixel address.
  localparam int IDX_W = (FRAMES > 1) ? FSEL_W + ADDR_W : ADDR_W;
  localparam int DEPTH = FRAMES * (2 ** ADDR_W);

  // One extra bit so "index < FRAMES" also works when FRAMES is a power of two.
  localparam logic [FSEL_W:0]   NFR  = (FSEL_W + 1)'(FRAMES);
  localparam logic [FSEL_W-1:0] LAST = FSEL_W'(FRAMES - 1);

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [PIX_W-1:0] mem [DEPTH];

  logic [FSEL_W-1:0] cur_frame_q, cur_frame_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic             wr_ok;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  // Frame-major layout: physical index = {frame, addr}. With non-power-of-two
  // FRAMES the top of the index space is simply never addressed.
  assign wr_ok  = wr_en && ({1'b0, wr_frame} < NFR);
  assign wr_idx = IDX_W'({wr_frame, wr_addr});
  assign rd_idx = IDX_W'({cur_frame_q, rd_addr});

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_idx] <= wr_data;
  end

  // ---------------------------------------------------------------------------
  // Read port. Both the write and this read use non-blocking updates on the
  // same edge, so a same-address collision returns the old word.
  // ---------------------------------------------------------------------------
  logic [PIX_W-1:0] rd_pix_q;
  logic             rd_vld_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pix_q <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_en;
      if (rd_en) rd_pix_q <= mem[rd_idx];
    end
  end

`ifdef FRAME_STORE_OUTREG_EN
  // Second output stage: data follows only valid reads so pix_val keeps its
  // last value across idle cycles; the valid flag tracks the first stage.
  logic [PIX_W-1:0] out_pix_q;
  logic             out_vld_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_pix_q <= '0;
      out_vld_q <= 1'b0;
    end else begin
      out_vld_q <= rd_vld_q;
      if (rd_vld_q) out_pix_q <= rd_pix_q;
    end
  end

  assign pix_val   = out_pix_q;
  assign pix_valid = out_vld_q;
`else
  assign pix_val   = rd_pix_q;
  assign pix_valid = rd_vld_q;
`endif

  // ---------------------------------------------------------------------------
  // Frame selection. Everything changes only on frame_tick, so a read issued
  // in the tick cycle still uses the old frame.
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_frame_d = cur_frame_q;
    hold_d      = hold_q;
    if (frame_tick) begin
      if (!anim_en) begin
        hold_d = '0;
        // Out-of-range selections are ignored rather than clamped.
        if ({1'b0, frame_sel} < NFR) cur_frame_d = frame_sel;
      end else if (hold_q == anim_hold) begin
        hold_d      = '0;
        cur_frame_d = (cur_frame_q == LAST) ? '0 : cur_frame_q + 1'b1;
      end else begin
        // Not cleared on entry to animation mode; if anim_hold is lowered
        // below the count, the counter wraps before it matches again.
        hold_d = hold_q + 1'b1;
      end
    end
    if (FRAMES == 1) cur_frame_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_frame_q <= '0;
      hold_q      <= '0;
    end else begin
      cur_frame_q <= cur_frame_d;
      hold_q      <= hold_d;
    end
  end

  assign cur_frame = cur_frame_q;

endmodule

// File: tb/tb_sprite_frame_store.sv
// Testbench for sprite_frame_store. FRAMES=6 is used so that out-of-range
// frame indices (6, 7) are representable on the 3-bit frame ports.
module tb_sprite_frame_store;

`ifdef FRAME_STORE_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int FR = 6;

  logic       clk = 1'b0;
  logic       reset, rd_en, wr_en, wr_data, frame_tick, anim_en;
  logic [5:0] rd_addr, wr_addr;
  logic [2:0] wr_frame, frame_sel, cur_frame;
  logic [3:0] anim_hold;
  logic       pix_val, pix_valid;

  int total = 0;
  int bad   = 0;

  sprite_frame_store #(
    .FRAMES(FR), .ADDR_W(6), .PIX_W(1), .HOLD_W(4), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset(reset),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .pix_val(pix_val), .pix_valid(pix_valid),
    .wr_en(wr_en), .wr_frame(wr_frame), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_tick(frame_tick), .anim_en(anim_en), .anim_hold(anim_hold),
    .frame_sel(frame_sel), .cur_frame(cur_frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [2:0] wf;
    logic [5:0] wa;
    logic       wd;
    logic       re;
    logic [5:0] ra;
    logic       ev;    // expected pix_val
    logic       evld;  // expected pix_valid
  } vec_t;

  vec_t tbl [12];

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rd_en = 1'b0; wr_en = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] a, input logic exp, input string nm);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    repeat (LAT - 1) tick();
    chk({nm, "_val"}, 32'(pix_val), 32'(exp));
    chk({nm, "_vld"}, 32'(pix_valid), 32'd1);
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
  endtask

  initial begin
    //            we    wf    wa    wd    re    ra    ev    evld
    tbl[0]  = '{1'b1, 3'd0, 6'd5, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 3'd1, 6'd5, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 3'd0, 6'd9, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 3'd3, 6'd5, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 3'd1, 6'd9, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 3'd0, 6'd0, 1'b0, 1'b1, 6'd5, 1'b1, 1'b1};  // f0 a5
    tbl[6]  = '{1'b0, 3'd0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0};  // idle: hold
    tbl[7]  = '{1'b1, 3'd0, 6'd9, 1'b1, 1'b1, 6'd9, 1'b0, 1'b1};  // read-first
    tbl[8]  = '{1'b0, 3'd0, 6'd0, 1'b0, 1'b1, 6'd9, 1'b1, 1'b1};  // now visible
    tbl[9]  = '{1'b1, 3'd6, 6'd9, 1'b0, 1'b1, 6'd9, 1'b1, 1'b1};  // dropped wr
    tbl[10] = '{1'b1, 3'd7, 6'd5, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0};  // dropped wr
    tbl[11] = '{1'b0, 3'd0, 6'd0, 1'b0, 1'b1, 6'd9, 1'b1, 1'b1};  // f0 a9 kept

    reset = 1'b1; idle_inputs();
    rd_addr = '0; wr_addr = '0; wr_frame = '0; wr_data = 1'b0;
    anim_en = 1'b0; anim_hold = '0; frame_sel = '0;
    tick(); tick();
    chk("rst_val", 32'(pix_val), 32'd0);
    chk("rst_vld", 32'(pix_valid), 32'd0);
    chk("rst_cur", 32'(cur_frame), 32'd0);
    reset = 1'b0;
    tick();

    // Table: writes/reads on frame 0.
    for (int i = 0; i < 12; i++) begin
      wr_en = tbl[i].we; wr_frame = tbl[i].wf; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      rd_en = tbl[i].re; rd_addr = tbl[i].ra;
      tick();
      idle_inputs();
      repeat (LAT - 1) tick();
      chk($sformatf("vec%0d_val", i), 32'(pix_val), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_vld", i), 32'(pix_valid), 32'(tbl[i].evld));
      chk($sformatf("vec%0d_cur", i), 32'(cur_frame), 32'd0);
    end

    // Manual select waits for frame_tick; a read in the tick cycle uses the old frame.
    frame_sel = 3'd1;
    repeat (3) tick();
    chk("man_no_tick", 32'(cur_frame), 32'd0);
    frame_tick = 1'b1; rd_en = 1'b1; rd_addr = 6'd5;
    tick();
    idle_inputs();
    chk("man_tick_cur", 32'(cur_frame), 32'd1);
    repeat (LAT - 1) tick();
    chk("tick_read_old", 32'(pix_val), 32'd1);
    do_read(6'd5, 1'b0, "f1_a5");
    do_read(6'd9, 1'b1, "f1_a9");

    // Out-of-range selections leave cur_frame alone.
    frame_sel = 3'd6; pulse_tick();
    chk("sel6_hold", 32'(cur_frame), 32'd1);
    frame_sel = 3'd7; pulse_tick();
    chk("sel7_hold", 32'(cur_frame), 32'd1);

    // Animation: hold=2 -> advance every 3rd tick, wrap 5 -> 0.
    frame_sel = 3'd0; pulse_tick();
    chk("anim_start", 32'(cur_frame), 32'd0);
    anim_en = 1'b1; anim_hold = 4'd2;
    for (int k = 1; k <= 20; k++) begin
      pulse_tick();
      tick();
      chk($sformatf("anim_t%0d", k), 32'(cur_frame), 32'((k / 3) % FR));
    end

    // Back to manual, select frame 3 for the reset test.
    anim_en = 1'b0; frame_sel = 3'd3; pulse_tick();
    chk("sel3", 32'(cur_frame), 32'd3);

    // Reset during a continuous read stream.
    rd_en = 1'b1; rd_addr = 6'd5;
    repeat (LAT) tick();
    chk("stream_val", 32'(pix_val), 32'd1);
    chk("stream_vld", 32'(pix_valid), 32'd1);
    reset = 1'b1;
    tick();
    chk("midrst_val", 32'(pix_val), 32'd0);
    chk("midrst_vld", 32'(pix_valid), 32'd0);
    chk("midrst_cur", 32'(cur_frame), 32'd0);
    reset = 1'b0;
    repeat (LAT) tick();
    chk("resume_val", 32'(pix_val), 32'd1);
    chk("resume_vld", 32'(pix_valid), 32'd1);
    chk("resume_cur", 32'(cur_frame), 32'd0);
    rd_en = 1'b0;
    tick();
    chk("stop_vld", 32'(pix_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
